// File: rtl/shift_mix_addkey_if.sv
// ============================================================================
//  Module      : shift_mix_addkey_if
//  Description : Input/output handshake bundle of the ShiftRows/MixColumns/
//                AddRoundKey round stage.
//                Upstream side : in_valid/in_ready, in_state, in_key, final_rnd
//                Downstream    : out_valid/out_ready, out_state
//                master modport = the environment (SubBytes feed + round
//                controller); slave modport = the round stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_mix_addkey_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         final_rnd;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_key, final_rnd, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_key, final_rnd, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

`default_nettype wire

// File: rtl/shift_mix_addkey.sv
// ============================================================================
//  Module      : shift_mix_addkey
//  Description : AES round stage following byte-serial SubBytes. Applies
//                ShiftRows on capture, then MixColumns (bypassed on the final
//                round) and AddRoundKey column-serially, MIX_COLS_PER_CYCLE
//                columns per clock, and presents the result on a valid/ready
//                handshake.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active low
//                bus  - handshake bundle (slave side): in_valid/in_ready,
//                       in_state, in_key, final_rnd, out_valid/out_ready,
//                       out_state. Byte 0 of every 128-bit word is at [127:120],
//                       column-major.
//                busy - high whenever the stage is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_mix_addkey #(
  parameter int MIX_COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  shift_mix_addkey_if.slave  bus,
  output logic               busy
);

  generate
    if (!(MIX_COLS_PER_CYCLE == 1 || MIX_COLS_PER_CYCLE == 2 ||
          MIX_COLS_PER_CYCLE == 4)) begin : g_bad_cols_per_cycle
      $error("shift_mix_addkey: MIX_COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Column index of the last group; the edge that processes it ends MIX.
  localparam logic [1:0] c_LAST_COL = 2'(4 - MIX_COLS_PER_CYCLE);
  localparam logic [1:0] c_COL_STEP = 2'(MIX_COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    // 3*x is expressed as xtime(x) ^ x
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Row r rotated left by r bytes: s'[r,c] = s[r,(c+r) mod 4].
  // Byte s[r,c] lives at [127 - 8*(4c + r) -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t       state_q;
  logic [127:0] work_q;      // shifted state, columns overwritten as they finish
  logic [127:0] work_d;
  logic [127:0] key_q;
  logic         final_q;
  logic [1:0]   col_q;       // first column of the group processed this cycle
  logic [127:0] out_q;

  logic [31:0]  w_col;
  logic [31:0]  w_res;
  int           w_idx;

  // Replace the current column group with its mixed-and-keyed result.
  always_comb begin
    work_d = work_q;
    w_col  = '0;
    w_res  = '0;
    w_idx  = 0;
    for (int g = 0; g < MIX_COLS_PER_CYCLE; g++) begin
      w_idx = int'(col_q) + g;
      w_col = work_q[127 - 32*w_idx -: 32];
      w_res = (final_q ? w_col : mix_col(w_col)) ^ key_q[127 - 32*w_idx -: 32];
      work_d[127 - 32*w_idx -: 32] = w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      key_q   <= '0;
      final_q <= 1'b0;
      col_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            work_q  <= shift_rows(bus.in_state);
            key_q   <= bus.in_key;
            final_q <= bus.final_rnd;
            col_q   <= '0;
            state_q <= ST_MIX;
          end
        end
        ST_MIX: begin
          work_q <= work_d;
          col_q  <= col_q + c_COL_STEP;
          if (col_q == c_LAST_COL) begin
            // work_d already holds every finished column at this point
            out_q   <= work_d;
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of the state register, so they carry no
  // combinational path from in_valid or out_ready.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_state = out_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_mix_addkey.sv
// ============================================================================
//  Module      : tb_shift_mix_addkey
//  Description : Directed self-checking bench for shift_mix_addkey using
//                FIPS-197 vectors and hand-computed MixColumns cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_mix_addkey;

  localparam int P = 1;
  localparam int L = 4 / P;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_errors;

  shift_mix_addkey_if bus ();

  shift_mix_addkey #(.MIX_COLS_PER_CYCLE(P)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one block, measure latency, optionally hold backpressure for
  // 'hold' cycles while disturbing the inputs, then complete the handshake.
  task automatic run_block(input string tag, input logic [127:0] st,
                           input logic [127:0] key, input logic fin,
                           input logic [127:0] exp, input int hold);
    int edges;
    logic [127:0] held;
    chk({tag, " in_ready idle"}, 128'(bus.in_ready), 128'(1));
    bus.in_state  = st;
    bus.in_key    = key;
    bus.final_rnd = fin;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    tick();
    bus.in_valid  = 1'b0;
    bus.final_rnd = ~fin;          // must not affect the block in flight
    bus.in_state  = ~st;
    edges = 1;
    while (!bus.out_valid && edges < 40) begin
      tick();
      edges++;
    end
    chk({tag, " latency"}, 128'(edges), 128'(L + 1));
    chk({tag, " out_state"}, bus.out_state, exp);
    held = bus.out_state;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk({tag, " hold out_valid"}, 128'(bus.out_valid), 128'(1));
      chk({tag, " hold out_state"}, bus.out_state, held);
      chk({tag, " hold in_ready"},  128'(bus.in_ready), 128'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, " post out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, " post in_ready"},  128'(bus.in_ready), 128'(1));
    chk({tag, " post out_state"}, bus.out_state, exp);
  endtask

  localparam logic [127:0] c_B1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] c_B1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] c_B1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] c_FR_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] c_FR_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] c_FR_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic seen;
    n_checks = 0;
    n_errors = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_state  = c_B1_IN;
    bus.in_key    = c_B1_KEY;
    bus.final_rnd = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held with in_valid asserted
    repeat (3) tick();
    chk("rst in_ready",  128'(bus.in_ready), 128'(1));
    chk("rst out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst out_state", bus.out_state, 128'h0);
    chk("rst busy",      128'(busy), 128'(0));
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk("rst no capture busy", 128'(busy), 128'(0));

    run_block("b1", c_B1_IN, c_B1_KEY, 1'b0, c_B1_OUT, 0);
    run_block("final", c_FR_IN, c_FR_KEY, 1'b1, c_FR_OUT, 0);

    // Pure MixColumns on column 0: s[r,r] carries row r so ShiftRows lands
    // db,13,53,45 in column 0 and zeros elsewhere.
    run_block("mixcol", 128'hdb000000001300000000530000000045, 128'h0, 1'b0,
              128'h8e4da1bc000000000000000000000000, 0);
    // Column 0 = db135345 unrotated: ShiftRows scatters rows 1..3 into
    // columns 3,2,1, giving ad db db 76 | 45 45 cf 8a | 53 f5 a6 53 | 35 26 13 13.
    run_block("shiftcol", 128'hdb135345000000000000000000000000, 128'h0, 1'b0,
              128'haddbdb764545cf8a53f5a65335261313, 0);

    run_block("backpressure", c_B1_IN, c_B1_KEY, 1'b0, c_B1_OUT, 10);

    // Reset on the second MIX edge discards the block
    bus.in_state  = c_B1_IN;
    bus.in_key    = c_B1_KEY;
    bus.final_rnd = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();                          // E0
    bus.in_valid = 1'b0;
    tick();                          // E1
    rst = 1'b0;
    tick();                          // E2 with reset
    rst = 1'b1;
    chk("midrst busy",      128'(busy), 128'(0));
    chk("midrst in_ready",  128'(bus.in_ready), 128'(1));
    chk("midrst out_state", bus.out_state, 128'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst no output", 128'(seen), 128'(0));
    bus.out_ready = 1'b0;

    run_block("final after rst", c_FR_IN, c_FR_KEY, 1'b1, c_FR_OUT, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
